wbrw_arbiter: RTL and testbench
===============================

WBRW_ARBITER -- requirements
Module: wbrw_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 26, WB word-address width; DW, default 32, WB data width; LGTIMEOUT, default 10, log2 of the watchdog limit.
REQ-002 Ports SHALL be (name, direction, width, meaning): i_clk, in, 1, clock; i_reset, in, 1, asynchronous active-high reset.
REQ-003 Port A (write bridge) SHALL be: i_a_cyc, i_a_stb, in, 1 each; i_a_addr, in, AW; i_a_data, in, DW; i_a_sel, in, DW/8; o_a_stall, o_a_ack, o_a_err, out, 1 each.
REQ-004 Port B (read bridge) SHALL be: i_b_cyc, i_b_stb, in, 1 each; i_b_addr, in, AW; o_b_data, out, DW; o_b_stall, o_b_ack, o_b_err, out, 1 each.
REQ-005 Master port SHALL be: o_wb_cyc, o_wb_stb, o_wb_we, out, 1 each; o_wb_addr, out, AW; o_wb_data, out, DW; o_wb_sel, out, DW/8; i_wb_stall, i_wb_ack, i_wb_err, in, 1 each; i_wb_data, in, DW.

Function
REQ-006 Grant state SHALL be registered, with states IDLE, GNT_A and GNT_B.
REQ-007 Transitions out of IDLE SHALL be: if only A has cyc&&stb, go to GNT_A; if only B, go to GNT_B; if both, grant the port not served last (round-robin).
REQ-008 Transitions out of GNT_x SHALL be: when i_x_cyc falls, go to GNT_y if y has cyc&&stb that cycle, else go to IDLE.
REQ-009 The grant SHALL never change while the owner holds cyc, except on watchdog expiry (REQ-016).
REQ-010 Arbitration latency SHALL be exactly one cycle: a request from IDLE is first visible on o_wb_stb the cycle after it is sampled.
REQ-011 While granted, the master outputs SHALL combinationally follow the owner: o_wb_cyc=i_x_cyc, o_wb_stb=i_x_stb, and addr/data/sel forwarded; o_wb_we=1 for A and 0 for B; o_wb_sel is all ones for B.
REQ-012 In IDLE, o_wb_cyc and o_wb_stb SHALL be 0; data/addr/sel are don't-care.
REQ-013 The owner SHALL receive o_x_stall=i_wb_stall, o_x_ack=i_wb_ack and o_x_err=i_wb_err. The non-owner SHALL receive stall=1, ack=0, err=0. In IDLE, both stalls SHALL be 1.
REQ-014 o_b_data SHALL equal i_wb_data unconditionally.
REQ-015 An outstanding counter, LGTIMEOUT bits and saturating, SHALL:
 - increment on stb&&!stall and decrement on ack|err; both in the same cycle leaves it unchanged;
 - clear when o_wb_cyc is low.
REQ-016 When the owner's cyc falls with the counter nonzero, the arbiter SHALL go to IDLE anyway; late acks go to no one.
REQ-017 Simultaneous owner cyc drop and other-port request SHALL switch directly to the other port with no IDLE cycle, and the last-served marker SHALL update.

Reset
REQ-018 On i_reset, asynchronously: state=IDLE, last-served=B (so A wins the first tie), counters=0, o_wb_cyc=o_wb_stb=0, all acks/errs=0, both stalls=1.
REQ-019 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err delivered to either port.

Configuration
REQ-020 With macro WBRW_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles where o_wb_cyc is high, (outstanding>0 or o_wb_stb), and there is no ack/err.
REQ-021 At watchdog count 2^LGTIMEOUT-1, the arbiter SHALL pulse o_x_err to the owner for one cycle, force o_wb_cyc=0 and hold the owner stalled until its cyc falls, then continue to IDLE.
REQ-022 The watchdog SHALL reset on any ack/err or on grant change.
REQ-023 Without WBRW_ARB_TIMEOUT_EN, no watchdog logic SHALL exist and the behaviour SHALL be exactly REQ-006..019.

Verification
REQ-024 Reset release, A requests at cycle 0 -> o_wb_stb=1 with we=1 at cycle 1; i_wb_ack at cycle 3 -> o_a_ack=1 at cycle 3, o_b_ack=0.
REQ-025 A and B request together from reset -> A granted. After A drops cyc, B is granted the next cycle; a second tie afterwards -> A granted.
REQ-026 B owner issues 4 stbs with stall alternating, 4 acks returned -> counter reaches 0, o_b_data matches i_wb_data on each ack, o_a_stall=1 throughout.
REQ-027 A drops cyc in the same cycle B raises cyc&&stb -> next cycle state=GNT_B, o_wb_we=0, no IDLE cycle.
REQ-028 With WBRW_ARB_TIMEOUT_EN and LGTIMEOUT=4: A stb accepted, no ack for 15 cycles -> o_a_err pulses once, o_wb_cyc=0; without the macro, the bus waits indefinitely.
REQ-029 i_reset asserted while B has 2 acks outstanding -> outputs reach reset values immediately, and later stray acks produce no port ack.

Source files
------------

// File: rtl/wbrw_arbiter.sv
// ============================================================================
//  Module   : wbrw_arbiter
//  Purpose  : Two-port Wishbone arbiter joining a write bridge (A) and a read
//             bridge (B) onto one pipelined master port. Round-robin on ties.
//             Optional bus watchdog enabled by macro WBRW_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbrw_arbiter #(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int LGTIMEOUT = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    // Port A: write bridge
    input  logic              i_a_cyc,
    input  logic              i_a_stb,
    input  logic [AW-1:0]     i_a_addr,
    input  logic [DW-1:0]     i_a_data,
    input  logic [DW/8-1:0]   i_a_sel,
    output logic              o_a_stall,
    output logic              o_a_ack,
    output logic              o_a_err,
    // Port B: read bridge
    input  logic              i_b_cyc,
    input  logic              i_b_stb,
    input  logic [AW-1:0]     i_b_addr,
    output logic [DW-1:0]     o_b_data,
    output logic              o_b_stall,
    output logic              o_b_ack,
    output logic              o_b_err,
    // Master port
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DW-1:0]     o_wb_data,
    output logic [DW/8-1:0]   o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [DW-1:0]     i_wb_data
);

    localparam logic [LGTIMEOUT-1:0] c_one = {{(LGTIMEOUT-1){1'b0}}, 1'b1};
    localparam logic [LGTIMEOUT-1:0] c_max = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_last_b;
    logic [LGTIMEOUT-1:0] r_outstanding;

    logic w_a_req, w_b_req;
    logic w_own_a, w_own_b;
    logic w_own_cyc, w_own_stb;
    logic w_inc, w_dec;
    logic w_kill, w_expire;

    assign w_a_req   = i_a_cyc && i_a_stb;
    assign w_b_req   = i_b_cyc && i_b_stb;
    assign w_own_a   = (r_state == GNT_A);
    assign w_own_b   = (r_state == GNT_B);
    assign w_own_cyc = (w_own_a && i_a_cyc) || (w_own_b && i_b_cyc);
    assign w_own_stb = (w_own_a && i_a_stb) || (w_own_b && i_b_stb);

`ifdef WBRW_ARB_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] r_wdog;
    logic                 r_abort;
    logic                 w_grant_change;

    assign w_grant_change = ((r_state == IDLE) && (w_a_req || w_b_req))
                         || ((r_state != IDLE) && !w_own_cyc);
    assign w_expire = (w_own_a || w_own_b) && !r_abort && (r_wdog == c_max);
    assign w_kill   = w_expire || r_abort;

    // Once expired, the owner stays stalled off the bus until it drops cyc.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wdog  <= '0;
            r_abort <= 1'b0;
        end else if (w_grant_change) begin
            r_wdog  <= '0;
            r_abort <= 1'b0;
        end else if (w_expire) begin
            r_wdog  <= '0;
            r_abort <= 1'b1;
        end else if (i_wb_ack || i_wb_err) begin
            r_wdog  <= '0;
        end else if (o_wb_cyc && ((r_outstanding != '0) || o_wb_stb)) begin
            r_wdog  <= r_wdog + c_one;
        end
    end
`else
    assign w_expire = 1'b0;
    assign w_kill   = 1'b0;
`endif

    // Master port follows the current owner combinationally.
    assign o_wb_cyc  = w_own_cyc && !w_kill;
    assign o_wb_stb  = w_own_stb && !w_kill;
    assign o_wb_we   = w_own_a;
    assign o_wb_addr = w_own_b ? i_b_addr : i_a_addr;
    assign o_wb_data = i_a_data;
    assign o_wb_sel  = w_own_b ? {(DW/8){1'b1}} : i_a_sel;

    assign o_a_stall = w_own_a ? (i_wb_stall || w_kill) : 1'b1;
    assign o_b_stall = w_own_b ? (i_wb_stall || w_kill) : 1'b1;
    assign o_a_ack   = w_own_a && !w_kill && i_wb_ack;
    assign o_b_ack   = w_own_b && !w_kill && i_wb_ack;
    assign o_a_err   = w_own_a && (w_expire || (!w_kill && i_wb_err));
    assign o_b_err   = w_own_b && (w_expire || (!w_kill && i_wb_err));
    assign o_b_data  = i_wb_data;

    assign w_inc = o_wb_stb && !i_wb_stall;
    assign w_dec = i_wb_ack || i_wb_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_outstanding <= '0;
        else if (!o_wb_cyc)
            r_outstanding <= '0;
        else if (w_inc && !w_dec && (r_outstanding != c_max))
            r_outstanding <= r_outstanding + c_one;
        else if (w_dec && !w_inc && (r_outstanding != '0))
            r_outstanding <= r_outstanding - c_one;
    end

    // A handover straight to the other port only happens with nothing in
    // flight, so late acks can never be delivered to the new owner.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_last_b <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_a_req && (!w_b_req || r_last_b)) begin
                        r_state  <= GNT_A;
                        r_last_b <= 1'b0;
                    end else if (w_b_req) begin
                        r_state  <= GNT_B;
                        r_last_b <= 1'b1;
                    end
                end
                GNT_A: begin
                    if (!i_a_cyc) begin
                        if (w_b_req && (r_outstanding == '0) && !w_kill) begin
                            r_state  <= GNT_B;
                            r_last_b <= 1'b1;
                        end else begin
                            r_state  <= IDLE;
                        end
                    end
                end
                GNT_B: begin
                    if (!i_b_cyc) begin
                        if (w_a_req && (r_outstanding == '0) && !w_kill) begin
                            r_state  <= GNT_A;
                            r_last_b <= 1'b0;
                        end else begin
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wbrw_arbiter.sv
// ============================================================================
//  Module   : tb_wbrw_arbiter
//  Purpose  : Self-checking bench for wbrw_arbiter: vector table, directed
//             multi-cycle sequences and randomized traffic vs. a port model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wbrw_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int LGT = 4;
    localparam int OMAX = (1 << LGT) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_cyc = 0, a_stb = 0, b_cyc = 0, b_stb = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, wb_idata = '0;
    logic [SW-1:0] a_sel = '0;
    logic wb_stall = 0, wb_ack = 0, wb_err = 0;
    logic a_stall, a_ack, a_err, b_stall, b_ack, b_err;
    logic [DW-1:0] b_data, wb_odata;
    logic wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [SW-1:0] wb_sel;

    int errors = 0;
    int checks = 0;

    wbrw_arbiter #(.AW(AW), .DW(DW), .LGTIMEOUT(LGT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_addr(a_addr), .i_a_data(a_data),
        .i_a_sel(a_sel), .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_addr(b_addr), .o_b_data(b_data),
        .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_odata), .o_wb_sel(wb_sel), .i_wb_stall(wb_stall),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_idata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] vin;   // {a_cyc,a_stb,b_cyc,b_stb,stall,ack,err}
        logic [8:0] exp;   // {cyc,stb,we,a_stall,b_stall,a_ack,b_ack,a_err,b_err}
        logic [8:0] care;
    } vec_t;

    localparam logic [8:0] ALL  = 9'h1FF;
    localparam logic [8:0] NOWE = 9'b110111111;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctl();
        return {wb_cyc, wb_stb, wb_we, a_stall, b_stall, a_ack, b_ack, a_err, b_err};
    endfunction

    task automatic drive(input logic [6:0] v);
        {a_cyc, a_stb, b_cyc, b_stb, wb_stall, wb_ack, wb_err} = v;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the falling edge.
    task automatic step(input logic [6:0] v);
        @(posedge clk);
        #1 drive(v);
        #4;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        drive(7'b0);
        repeat (2) @(posedge clk);
        #5 rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[17];
        int   m_own, m_lastb, m_out, n_out, errs;
        logic e_cyc, e_stb;
        logic [8:0] e9, c9;
        logic [63:0] gdp, edp;

        // Reset state, even with requests and a bus ack present.
        #2 drive(7'b1111_010);
        #10 chk("reset_outputs", {55'd0, ctl()}, {55'd0, 9'b000110000});
        do_reset();

        // Vector table: each row is one cycle, starting from IDLE after reset.
        tbl[0]  = '{7'b1100_000, 9'b000110000, NOWE};
        tbl[1]  = '{7'b1100_000, 9'b111010000, ALL};
        tbl[2]  = '{7'b1000_000, 9'b101010000, ALL};
        tbl[3]  = '{7'b1000_010, 9'b101011000, ALL};
        tbl[4]  = '{7'b0011_000, 9'b001010000, ALL};
        tbl[5]  = '{7'b0011_000, 9'b110100000, ALL};
        tbl[6]  = '{7'b0010_001, 9'b100100001, ALL};
        tbl[7]  = '{7'b0000_000, 9'b000100000, ALL};
        tbl[8]  = '{7'b1111_000, 9'b000110000, NOWE};
        tbl[9]  = '{7'b1111_100, 9'b111110000, ALL};
        tbl[10] = '{7'b0011_000, 9'b001010000, ALL};
        tbl[11] = '{7'b1111_000, 9'b110100000, ALL};
        tbl[12] = '{7'b1100_000, 9'b000100000, ALL};
        tbl[13] = '{7'b1111_000, 9'b000110000, NOWE};
        tbl[14] = '{7'b1100_100, 9'b111110000, ALL};
        tbl[15] = '{7'b0000_000, 9'b001010000, ALL};
        tbl[16] = '{7'b0000_000, 9'b000110000, NOWE};
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].vin);
            chk($sformatf("vec%0d", i), {55'd0, ctl() & tbl[i].care},
                {55'd0, tbl[i].exp & tbl[i].care});
        end

        // B burst: 4 stbs with alternating stall, then 4 acks with read data.
        do_reset();
        step(7'b0011_000);
        for (int k = 0; k < 8; k++) begin
            step({4'b0011, (k % 2 == 0), 2'b00});
            chk("burst_stall", {62'd0, a_stall, b_stall}, {62'd0, 1'b1, (k % 2 == 0)});
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 drive(7'b0010_010);
            wb_idata = $urandom;
            #4 chk("burst_ack", {30'd0, a_stall, b_ack, b_data},
                   {30'd0, 1'b1, 1'b1, wb_idata});
        end
        step(7'b1100_000);
        step(7'b1100_000);
        chk("burst_drained_switch", {62'd0, wb_cyc, wb_we}, {62'd0, 2'b11});

        // Reset with two reads outstanding: transfer abandoned, stray acks dropped.
        do_reset();
        step(7'b0011_000);
        step(7'b0011_000);
        step(7'b0011_000);
        @(posedge clk);
        #1 drive(7'b0010_000);
        #1 rst = 1'b1;
        #1 wb_ack = 1'b1;
        #1 chk("async_reset", {55'd0, ctl()}, {55'd0, 9'b000110000});
        drive(7'b0);
        repeat (2) @(posedge clk);
        #5 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(7'b0000_010);
            chk("stray_ack", {62'd0, a_ack, b_ack}, 64'd0);
        end

        // Write accepted and never acknowledged.
        do_reset();
        step(7'b1100_000);
        step(7'b1100_000);
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            step(7'b1000_000);
            if (a_err) errs++;
        end
`ifdef WBRW_ARB_TIMEOUT_EN
        chk("wdog_err_pulses", 64'(errs), 64'd1);
        chk("wdog_bus_dropped", {62'd0, wb_cyc, a_stall}, {62'd0, 2'b01});
        step(7'b0000_000);
        step(7'b0000_000);
        chk("wdog_idle", {55'd0, ctl()}, {55'd0, 9'b000110000});
`else
        chk("nowdog_err_pulses", 64'(errs), 64'd0);
        chk("nowdog_bus_held", {62'd0, wb_cyc, wb_we}, {62'd0, 2'b11});
`endif

`ifndef WBRW_ARB_TIMEOUT_EN
        // Randomized traffic against a grant/outstanding model of the rules.
        do_reset();
        m_own = 0; m_lastb = 1; m_out = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) a_cyc = !a_cyc;
            if ($urandom_range(0, 7) == 0) b_cyc = !b_cyc;
            a_stb    = a_cyc && ($urandom_range(0, 1) == 1);
            b_stb    = b_cyc && ($urandom_range(0, 1) == 1);
            wb_stall = ($urandom_range(0, 2) == 0);
            wb_ack   = ($urandom_range(0, 2) == 0);
            wb_err   = ($urandom_range(0, 15) == 0);
            a_addr   = AW'($urandom);
            b_addr   = AW'($urandom);
            a_data   = $urandom;
            a_sel    = SW'($urandom);
            wb_idata = $urandom;
            #4;
            e_cyc = (m_own == 1) ? a_cyc : (m_own == 2) ? b_cyc : 1'b0;
            e_stb = (m_own == 1) ? a_stb : (m_own == 2) ? b_stb : 1'b0;
            e9 = {e_cyc, e_stb, (m_own == 1),
                  (m_own == 1) ? wb_stall : 1'b1,
                  (m_own == 2) ? wb_stall : 1'b1,
                  (m_own == 1) && wb_ack, (m_own == 2) && wb_ack,
                  (m_own == 1) && wb_err, (m_own == 2) && wb_err};
            c9 = (m_own == 0) ? NOWE : ALL;
            chk($sformatf("rand_ctl@%0d", cyc), {23'd0, ctl() & c9, b_data},
                {23'd0, e9 & c9, wb_idata});
            if (m_own != 0) begin
                gdp = {2'd0, wb_addr, (m_own == 1) ? wb_odata : 32'd0, wb_sel};
                edp = {2'd0, (m_own == 1) ? a_addr : b_addr,
                       (m_own == 1) ? a_data : 32'd0,
                       (m_own == 1) ? a_sel : 4'hF};
                chk($sformatf("rand_dp@%0d", cyc), gdp, edp);
            end
            // Model update for the coming edge.
            if (!e_cyc) n_out = 0;
            else begin
                n_out = m_out + int'(e_stb && !wb_stall) - int'(wb_ack || wb_err);
                if (n_out < 0) n_out = 0;
                if (n_out > OMAX) n_out = OMAX;
            end
            if (m_own == 0) begin
                if ((a_cyc && a_stb) && (b_cyc && b_stb)) m_own = m_lastb ? 1 : 2;
                else if (a_cyc && a_stb) m_own = 1;
                else if (b_cyc && b_stb) m_own = 2;
            end else if (!e_cyc) begin
                if (m_out == 0 && m_own == 1 && b_cyc && b_stb) m_own = 2;
                else if (m_out == 0 && m_own == 2 && a_cyc && a_stb) m_own = 1;
                else m_own = 0;
            end
            if (m_own != 0) m_lastb = (m_own == 2) ? 1 : 0;
            m_out = n_out;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
